bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: instruction fetch (read-only) and the memory stage (load/store).
- Sequences one bus transaction at a time with a valid/ready handshake and registered bus outputs.
- Converts byte/half/word accesses into word-aligned bus cycles with byte strobes.
- Returns per-requester ready pulses; the hazard unit uses these to drive its stalls.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while fetch waits before fetch is forced a grant (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch read request; held until fetch_ready
fetch_addr  in  32  fetch address, word aligned, stable while fetch_req
fetch_cancel  in  1  fetch discards its outstanding or pending request (branch taken)
fetch_ready  out  1  one-cycle pulse: fetch_data valid
fetch_data  out  32  instruction word
mem_load  in  1  load request; held until mem_ready
mem_store  in  1  store request; held until mem_ready
mem_addr  in  32  byte address, alignment already checked by the memory stage
mem_size  in  2  00 byte, 01 half, 10 word
mem_store_data  in  32  store data, right-aligned
mem_ready  out  1  one-cycle pulse: access complete
mem_load_data  out  32  load data right-aligned, not extended (writeback extends)
bus_valid  out  1  transaction valid
bus_write  out  1  1 = write
bus_addr  out  32  word address, bits [1:0] = 0
bus_wdata  out  32  lane-replicated write data
bus_wstrb  out  4  byte strobes; 0000 on reads
bus_ready  in  1  slave accepts/completes in the cycle bus_valid && bus_ready
bus_rdata  in  32  read data, valid with bus_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; starve counter 0; cancel flag 0. Reset mid-transaction drops bus_valid immediately; no ready pulse is produced.
- States: IDLE, FETCH, DATA, RESP.
- IDLE -> FETCH/DATA on a request; the winner's address and data are latched and bus_valid goes high the next cycle.
- FETCH/DATA hold all bus outputs stable until bus_ready. On the bus_ready cycle M: rdata is latched, bus_valid deasserts at M+1, state -> RESP.
- RESP lasts exactly one cycle (M+1). The winner's ready pulse is issued here with registered data, then state -> IDLE. No grant is made in RESP, since the requester still holds its request that cycle.
- Minimum latency: request in cycle N -> bus_valid N+1 -> with zero-wait slave, ready pulse at N+2, next grant possible at N+3.
- Arbitration in IDLE:
  - Data wins over fetch, unless starve counter == STARVE_LIMIT and fetch_req is set.
  - Starve counter increments on each data grant while fetch_req is high, saturating at STARVE_LIMIT. It clears on any fetch grant.
- mem_load && mem_store together: treated as store (simulation assertion flags it).
- mem_size 11: treated as word (assertion).
- Address/strobe rules:
  - bus_addr = {addr[31:2],2'b00}.
  - Byte: wstrb = 0001<<addr[1:0]; wdata = {4{d[7:0]}}.
  - Half: wstrb = 0011<<{addr[1],1'b0}; wdata = {2{d[15:0]}}.
  - Word: wstrb = 1111; wdata = d.
  - Load: mem_load_data = rdata >> (8*addr[1:0]); upper bytes are whatever shifted in (no extension).
- fetch_cancel:
  - Sampled in IDLE with fetch_req: fetch is not granted that cycle.
  - Sampled in FETCH: cancel flag is set. The bus transaction still completes (never abandoned), RESP suppresses fetch_ready, and the flag clears.
  - Has no effect in DATA or RESP.
- fetch_ready and mem_ready are never high in the same cycle. At most one transaction is outstanding.

Decomposition:
- Shared package: state encoding (ARB_IDLE/FETCH/DATA/RESP), size codes (SIZE_BYTE/HALF/WORD), shared with memory and writeback stages.
- One sub-module: bus_lane_align, combinational: size + addr[1:0] + data -> wstrb/wdata for stores, and rdata -> right-aligned load data.

Test Plan:
- Fetch only, addr 0x100, zero-wait slave returning 0x00000013 -> bus_valid at N+1 with addr 0x100, wstrb 0000; fetch_ready at N+2 with fetch_data 0x00000013.
- Simultaneous fetch_req and mem_store (addr 0x203, size 00, data 0xAB) -> data granted first: bus_addr 0x200, wstrb 1000, wdata 0xABABABAB; fetch granted after RESP.
- Half load at 0x102, bus_rdata 0xBEEF1234, bus_ready delayed 3 cycles -> bus outputs stable for 3 cycles; mem_load_data 0x0000BEEF at mem_ready.
- Continuous mem_load with fetch_req high, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant; counter clears after the fetch grant.
- fetch_cancel pulsed during FETCH wait -> transaction completes on bus; no fetch_ready pulse; next IDLE grants normally.
- rst_n low while in DATA with bus_valid=1 -> bus_valid 0 asynchronously; after release state IDLE, no mem_ready pulse.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: arbiter state and access size encodings shared with the memory and writeback stages
package bus_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_DATA, ARB_RESP} arb_state_t;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
endpackage

// File: rtl/bus_lane_align.sv
// bus_lane_align: maps byte/half/word accesses onto the 32-bit bus byte lanes
module bus_lane_align
    import bus_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    // any size code other than byte/half falls through to a full word
    assign wstrb = size == SIZE_BYTE ? 4'b0001 << offset :
                   size == SIZE_HALF ? 4'b0011 << {offset[1], 1'b0} : 4'b1111;
    assign wdata = size == SIZE_BYTE ? {4{store_data[7:0]}} :
                   size == SIZE_HALF ? {2{store_data[15:0]}} : store_data;
    assign load_data = rdata >> {offset, 3'b000};
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the memory bus between fetch and the memory stage, one transaction at a time
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_cancel,
    output logic        fetch_ready,
    output logic [31:0] fetch_data,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_store_data,
    output logic        mem_ready,
    output logic [31:0] mem_load_data,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    arb_state_t state, state_n;
    logic [3:0] starve;
    logic cancel_q;
    logic [1:0] off_q;
    logic mem_req, fetch_ok, grant_data, grant_fetch, done;
    logic [3:0] lane_wstrb;
    logic [31:0] lane_wdata, lane_load;
    assign mem_req = mem_load | mem_store;
    assign fetch_ok = fetch_req & ~fetch_cancel;
    assign grant_data = mem_req & ~(fetch_ok && starve == LIMIT);
    assign grant_fetch = fetch_ok & ~grant_data;
    assign done = (state == ARB_FETCH || state == ARB_DATA) && bus_ready;
    // store lanes come from the live request in IDLE; load alignment uses the latched offset
    bus_lane_align u_align (
        .size(mem_size),
        .offset(state == ARB_IDLE ? mem_addr[1:0] : off_q),
        .store_data(mem_store_data),
        .rdata(bus_rdata),
        .wstrb(lane_wstrb),
        .wdata(lane_wdata),
        .load_data(lane_load)
    );
    always_comb begin
        state_n = state == ARB_IDLE ? (grant_data ? ARB_DATA : grant_fetch ? ARB_FETCH : ARB_IDLE) :
                  state == ARB_RESP ? ARB_IDLE : done ? ARB_RESP : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ready <= 1'b0;
            fetch_data <= '0;
            mem_ready <= 1'b0;
            mem_load_data <= '0;
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            starve <= '0;
            cancel_q <= 1'b0;
            off_q <= '0;
        end else begin
            fetch_ready <= 1'b0;
            mem_ready <= 1'b0;
            if (state == ARB_IDLE && (grant_data || grant_fetch)) begin
                bus_valid <= 1'b1;
                bus_write <= grant_data & mem_store;
                bus_addr <= (grant_data ? mem_addr : fetch_addr) & ~32'h3;
                bus_wdata <= grant_data & mem_store ? lane_wdata : '0;
                bus_wstrb <= grant_data & mem_store ? lane_wstrb : '0;
                off_q <= mem_addr[1:0];
                starve <= grant_fetch ? '0 : fetch_req && starve != LIMIT ? starve + 4'd1 : starve;
            end
            if (state == ARB_FETCH && fetch_cancel) cancel_q <= 1'b1;
            if (done) begin
                bus_valid <= 1'b0;
                fetch_ready <= state == ARB_FETCH && !cancel_q && !fetch_cancel;
                mem_ready <= state == ARB_DATA;
                if (state == ARB_FETCH) fetch_data <= bus_rdata;
                else if (!bus_write) mem_load_data <= lane_load;
            end
            if (state == ARB_RESP) cancel_q <= 1'b0;
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_load && mem_store));
    assert property (@(posedge clk) disable iff (!rst_n) !mem_req || mem_size <= SIZE_WORD);
    assert property (@(posedge clk) disable iff (!rst_n) !(fetch_ready && mem_ready));
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table plus hand sequences for arbitration, cancel and reset
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_req, fetch_cancel, fetch_ready, mem_load, mem_store, mem_ready;
    logic bus_valid, bus_write, bus_ready;
    logic [31:0] fetch_addr, fetch_data, mem_addr, mem_store_data, mem_load_data;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0] mem_size;
    logic [3:0] bus_wstrb;
    int errors = 0, checks = 0, n;
    always #5 clk = ~clk;
    bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_cancel(fetch_cancel),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_store_data(mem_store_data), .mem_ready(mem_ready), .mem_load_data(mem_load_data),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );
    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic [31:0] addr, wd, rd, e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_load;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        vecs[0] = '{1'b1, SIZE_BYTE, 32'h203, 32'h000000AB, 32'h0, 32'h200, 4'b1000, 32'hABABABAB, 32'h0};
        vecs[1] = '{1'b1, SIZE_BYTE, 32'h200, 32'h12345678, 32'h0, 32'h200, 4'b0001, 32'h78787878, 32'h0};
        vecs[2] = '{1'b1, SIZE_HALF, 32'h302, 32'h0000BEEF, 32'h0, 32'h300, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[3] = '{1'b1, SIZE_HALF, 32'h300, 32'h1234CAFE, 32'h0, 32'h300, 4'b0011, 32'hCAFECAFE, 32'h0};
        vecs[4] = '{1'b1, SIZE_WORD, 32'h404, 32'hDEADBEEF, 32'h0, 32'h404, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b0, SIZE_BYTE, 32'h501, 32'h0, 32'h11223344, 32'h500, 4'b0000, 32'h0, 32'h00112233};
        vecs[6] = '{1'b0, SIZE_WORD, 32'h600, 32'h0, 32'hCAFEBABE, 32'h600, 4'b0000, 32'h0, 32'hCAFEBABE};
        vecs[7] = '{1'b0, SIZE_HALF, 32'h102, 32'h0, 32'hBEEF1234, 32'h100, 4'b0000, 32'h0, 32'h0000BEEF};
        vecs[8] = '{1'b0, SIZE_BYTE, 32'h703, 32'h0, 32'hA1B2C3D4, 32'h700, 4'b0000, 32'h0, 32'h000000A1};
        fetch_req = 0; fetch_cancel = 0; fetch_addr = '0;
        mem_load = 0; mem_store = 0; mem_addr = '0; mem_size = SIZE_WORD; mem_store_data = '0;
        bus_ready = 0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_bus_valid", 32'(bus_valid), 0);
        chk("rst_bus_write", 32'(bus_write), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 0);
        chk("rst_fetch_ready", 32'(fetch_ready), 0);
        chk("rst_mem_ready", 32'(mem_ready), 0);
        rst_n = 1;
        fetch_req = 1; fetch_addr = 32'h100;
        @(negedge clk);
        chk("fetch_valid", 32'(bus_valid), 1);
        chk("fetch_addr", bus_addr, 32'h100);
        chk("fetch_wstrb", 32'(bus_wstrb), 0);
        chk("fetch_write", 32'(bus_write), 0);
        bus_ready = 1; bus_rdata = 32'h00000013;
        @(negedge clk);
        chk("fetch_ready", 32'(fetch_ready), 1);
        chk("fetch_data", fetch_data, 32'h00000013);
        chk("fetch_mem_ready", 32'(mem_ready), 0);
        chk("fetch_valid_drop", 32'(bus_valid), 0);
        fetch_req = 0; bus_ready = 0;
        @(negedge clk);
        chk("fetch_ready_pulse", 32'(fetch_ready), 0);
        foreach (vecs[i]) begin
            mem_store = vecs[i].store; mem_load = !vecs[i].store; mem_size = vecs[i].size;
            mem_addr = vecs[i].addr; mem_store_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(bus_valid), 1);
            chk($sformatf("vec%0d_write", i), 32'(bus_write), 32'(vecs[i].store));
            chk($sformatf("vec%0d_addr", i), bus_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_wstrb", i), 32'(bus_wstrb), 32'(vecs[i].e_strb));
            if (vecs[i].store) chk($sformatf("vec%0d_wdata", i), bus_wdata, vecs[i].e_wdata);
            bus_ready = 1; bus_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 1);
            chk($sformatf("vec%0d_fetch_ready", i), 32'(fetch_ready), 0);
            if (!vecs[i].store) chk($sformatf("vec%0d_load", i), mem_load_data, vecs[i].e_load);
            mem_load = 0; mem_store = 0; bus_ready = 0;
            @(negedge clk);
        end
        fetch_req = 1; fetch_addr = 32'h140;
        mem_store = 1; mem_size = SIZE_BYTE; mem_addr = 32'h203; mem_store_data = 32'hAB;
        @(negedge clk);
        chk("both_write", 32'(bus_write), 1);
        chk("both_addr", bus_addr, 32'h200);
        chk("both_wstrb", 32'(bus_wstrb), 32'h8);
        chk("both_wdata", bus_wdata, 32'hABABABAB);
        bus_ready = 1;
        @(negedge clk);
        chk("both_mem_ready", 32'(mem_ready), 1);
        chk("both_fetch_ready", 32'(fetch_ready), 0);
        mem_store = 0; bus_ready = 0;
        @(negedge clk);
        chk("both_no_resp_grant", 32'(bus_valid), 0);
        @(negedge clk);
        chk("both_fetch_valid", 32'(bus_valid), 1);
        chk("both_fetch_addr", bus_addr, 32'h140);
        chk("both_fetch_write", 32'(bus_write), 0);
        bus_ready = 1; bus_rdata = 32'h00000093;
        @(negedge clk);
        chk("both_fetch_ready", 32'(fetch_ready), 1);
        chk("both_fetch_data", fetch_data, 32'h00000093);
        fetch_req = 0; bus_ready = 0;
        @(negedge clk);
        mem_load = 1; mem_size = SIZE_HALF; mem_addr = 32'h102;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk($sformatf("wait%0d_valid", w), 32'(bus_valid), 1);
            chk($sformatf("wait%0d_addr", w), bus_addr, 32'h100);
            chk($sformatf("wait%0d_wstrb", w), 32'(bus_wstrb), 0);
            chk($sformatf("wait%0d_mem_ready", w), 32'(mem_ready), 0);
        end
        bus_ready = 1; bus_rdata = 32'hBEEF1234;
        @(negedge clk);
        chk("wait_mem_ready", 32'(mem_ready), 1);
        chk("wait_load", mem_load_data, 32'h0000BEEF);
        mem_load = 0; bus_ready = 0;
        @(negedge clk);
        n = 0;
        fetch_req = 1; fetch_addr = 32'h1000; mem_load = 1; mem_size = SIZE_WORD; mem_addr = 32'h2000;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (bus_valid && !bus_ready) begin
                chk($sformatf("starve_grant%0d_is_fetch", n), 32'(bus_addr == 32'h1000), 32'(n % 5 == 4));
                n++;
            end
            bus_ready = bus_valid;
        end
        if (n < 10) begin
            checks++; errors++;
            $display("FAIL starve_timeout: got %0d grants expected 10", n);
        end
        fetch_req = 0; mem_load = 0;
        repeat (3) @(negedge clk);
        bus_ready = 0;
        @(negedge clk);
        fetch_req = 1; fetch_cancel = 1; fetch_addr = 32'h180;
        @(negedge clk);
        chk("cancel_idle_nogrant", 32'(bus_valid), 0);
        fetch_cancel = 0;
        @(negedge clk);
        chk("cancel_valid", 32'(bus_valid), 1);
        chk("cancel_addr", bus_addr, 32'h180);
        fetch_cancel = 1; fetch_req = 0;
        @(negedge clk);
        chk("cancel_held", 32'(bus_valid), 1);
        fetch_cancel = 0; bus_ready = 1; bus_rdata = 32'h99;
        @(negedge clk);
        chk("cancel_no_ready", 32'(fetch_ready), 0);
        chk("cancel_done", 32'(bus_valid), 0);
        bus_ready = 0;
        @(negedge clk);
        chk("cancel_no_ready_late", 32'(fetch_ready), 0);
        fetch_req = 1; fetch_addr = 32'h1C0;
        @(negedge clk);
        chk("after_cancel_valid", 32'(bus_valid), 1);
        chk("after_cancel_addr", bus_addr, 32'h1C0);
        bus_ready = 1; bus_rdata = 32'h55;
        @(negedge clk);
        chk("after_cancel_ready", 32'(fetch_ready), 1);
        chk("after_cancel_data", fetch_data, 32'h55);
        fetch_req = 0; bus_ready = 0;
        @(negedge clk);
        mem_load = 1; mem_size = SIZE_WORD; mem_addr = 32'h800;
        @(negedge clk);
        chk("rstmid_valid", 32'(bus_valid), 1);
        #2 rst_n = 0;
        #1 chk("rstmid_async_valid", 32'(bus_valid), 0);
        mem_load = 0; bus_ready = 1;
        @(negedge clk);
        rst_n = 1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk($sformatf("rstmid%0d_mem_ready", r), 32'(mem_ready), 0);
            chk($sformatf("rstmid%0d_valid", r), 32'(bus_valid), 0);
        end
        bus_ready = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
